mdu_unit: RTL and testbench
===========================

Name: mdu_unit

Overview:
- Parametrised multi-cycle multiply/divide unit that owns the HI/LO register pair.
- Sits beside the E-stage ALU of the pipelined MIPS core and executes mult/multu/div/divu/madd/maddu/msub/msubu/mthi/mtlo.
- Models fixed-latency iterative hardware with a busy flag; the hazard unit stalls on this flag for mfhi/mflo and for further MDU instructions.
- Adds multiply-accumulate, operand-width parametrisation and exception-driven cancel, none of which the ALU has.

Parameters:
- WIDTH, 32: operand width; HI and LO are each WIDTH bits.
- MULT_LAT, 5: busy cycles for all multiply and multiply-accumulate ops (must be >= 1).
- DIV_LAT, 10: busy cycles for div/divu (must be >= 1).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high; clears all state.
- start  input  1  E-stage MDU instruction valid this cycle.
- op  input  4  1=MULT 2=MULTU 3=DIV 4=DIVU 5=MTHI 6=MTLO 7=MADD 8=MADDU 9=MSUB 10=MSUBU; other values are a no-op.
- A  input  WIDTH  rs operand.
- B  input  WIDTH  rt operand.
- cancel  input  1  exception/eret flush from the M stage; blocks acceptance this cycle.
- busy  output  1  operation in flight.
- hi  output  WIDTH  architectural HI.
- lo  output  WIDTH  architectural LO.

Behaviour:
- Reset (async): hi=0, lo=0, busy=0, counter=0, pending result cleared. A reset mid-operation abandons the operation; no write occurs.
- Accept condition: start && !busy && !cancel && valid op. Otherwise start is ignored; HI/LO are unchanged and no error is raised.
- MTHI/MTLO: hi or lo <= A at the accepting edge. busy stays 0.
- Arithmetic ops, edge t accepting: the full 2*WIDTH result is computed from A and B as sampled at edge t and held in a pending register. busy=1 after edge t. Counter loads LAT-1.
- Each following edge decrements the counter. At edge t+LAT, {hi,lo} <= pending and busy <= 0. Busy is therefore high for exactly LAT cycles.
- HI/LO never show partial or early values. Reads during busy return the old values; the hazard unit guarantees no such read is consumed.
- MULT/MULTU: {hi,lo} = signed/unsigned A*B, 2*WIDTH bits.
- MADD/MADDU: {hi,lo} = {hi,lo} + A*B, using the product's signedness and modulo 2^(2*WIDTH). The {hi,lo} operand is taken at completion time, which equals its value at acceptance because no write can occur while busy.
- MSUB/MSUBU: same as MADD/MADDU, but {hi,lo} - A*B.
- DIV: lo = quotient truncated toward zero; hi = remainder carrying the sign of the dividend.
- DIV with A = -2^(WIDTH-1) and B = -1: lo = A, hi = 0.
- DIVU: unsigned quotient and remainder.
- Divide by zero (B=0): unit still busy for DIV_LAT cycles; hi and lo keep their old values.
- cancel while busy has no effect: an accepted op is architecturally committed because it reached E before the faulting instruction.
- cancel with start in the same cycle: not accepted, no state change.
- start while busy: ignored. This never occurs with a correct stall; the bench checks it regardless.
- No overflow or exception output; MDU ops never trap.

Decomposition:
- Shared package holds the op encodings (MDU_MULT..MDU_MSUBU, MDU_MTHI, MDU_MTLO), MULT_LAT/DIV_LAT defaults, and a counter width constant of $clog2(max(MULT_LAT,DIV_LAT)+1).
- The decode/control unit uses the same package for its op field.
- One natural sub-module: mdu_calc. It is purely combinational and produces the 2*WIDTH pending result from op, A, B and {hi,lo}.
- The top holds the counter, busy FSM (IDLE/BUSY) and HI/LO registers.

Test Plan:
- MULT A=0xFFFFFFFE (-2), B=3 -> busy high 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA. MULTU with the same operands -> hi=0x00000002, lo=0xFFFFFFFA.
- DIV A=-7 (0xFFFFFFF9), B=2 -> busy high 10 cycles; then lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- MTHI A=5 then MTLO A=7, then DIVU A=9, B=0 -> hi=5, lo=7 after 10 busy cycles.
- MTHI 0, MTLO 10, then MSUB A=3, B=4 -> {hi,lo}=0xFFFFFFFF_FFFFFFFE. MADDU A=0xFFFFFFFF, B=2 from hi=0, lo=1 -> hi=1, lo=0xFFFFFFFF.
- MULT accepted; start MTHI asserted in cycle 2 of busy; cancel pulsed in cycle 3 -> MTHI ignored, MULT result written on schedule. start+cancel in the same cycle -> busy stays 0, hi/lo unchanged.
- DIV accepted, reset asserted in cycle 4 -> hi=lo=0 and busy=0 immediately. No write occurs afterwards.

Source files
------------

// File: rtl/mdu_unit_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings, default
// latencies and the busy-counter width helper.
package mdu_unit_pkg;

    typedef enum logic [3:0] {
        MDU_NOP   = 4'd0,
        MDU_MULT  = 4'd1,
        MDU_MULTU = 4'd2,
        MDU_DIV   = 4'd3,
        MDU_DIVU  = 4'd4,
        MDU_MTHI  = 4'd5,
        MDU_MTLO  = 4'd6,
        MDU_MADD  = 4'd7,
        MDU_MADDU = 4'd8,
        MDU_MSUB  = 4'd9,
        MDU_MSUBU = 4'd10
    } mdu_op_e;

    localparam int MDU_MULT_LAT = 5;
    localparam int MDU_DIV_LAT  = 10;

    function automatic int mdu_cnt_width(input int mult_lat, input int div_lat);
        int max_lat;
        max_lat = (mult_lat > div_lat) ? mult_lat : div_lat;
        return $clog2(max_lat + 1);
    endfunction

    localparam int MDU_CNT_W = mdu_cnt_width(MDU_MULT_LAT, MDU_DIV_LAT);

    function automatic logic mdu_op_valid(input logic [3:0] op);
        return (op >= 4'(MDU_MULT)) && (op <= 4'(MDU_MSUBU));
    endfunction

endpackage

// File: rtl/mdu_unit_calc.sv
// Combinational datapath: full 2*WIDTH result for multiply, multiply-accumulate
// and divide ops, plus a write-enable that is low for divide by zero.
module mdu_calc
    import mdu_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [3:0]         op,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic [WIDTH-1:0]   hi,
    input  logic [WIDTH-1:0]   lo,
    output logic [2*WIDTH-1:0] result,
    output logic               wr_en
);

    logic                      signed_op;
    logic [2*WIDTH-1:0]        a_ext;
    logic [2*WIDTH-1:0]        b_ext;
    logic [2*WIDTH-1:0]        product;
    logic [2*WIDTH-1:0]        acc;
    logic [WIDTH-1:0]          uq;
    logic [WIDTH-1:0]          ur;
    logic signed [WIDTH-1:0]   sa;
    logic signed [WIDTH-1:0]   sb;
    logic signed [WIDTH-1:0]   sq;
    logic signed [WIDTH-1:0]   sr;
    logic [WIDTH-1:0]          int_min;

    always_comb begin
        signed_op = (op == 4'(MDU_MULT)) || (op == 4'(MDU_DIV)) ||
                    (op == 4'(MDU_MADD)) || (op == 4'(MDU_MSUB));
        a_ext   = signed_op ? {{WIDTH{a[WIDTH-1]}}, a} : {{WIDTH{1'b0}}, a};
        b_ext   = signed_op ? {{WIDTH{b[WIDTH-1]}}, b} : {{WIDTH{1'b0}}, b};
        // Truncating the 2W x 2W product of extended operands gives the exact
        // signed or unsigned 2W-bit product.
        product = a_ext * b_ext;
        acc     = {hi, lo};

        int_min = '0;
        int_min[WIDTH-1] = 1'b1;
        sa = a;
        sb = b;
        uq = '0;
        ur = '0;
        sq = '0;
        sr = '0;
        if (b != '0) begin
            uq = a / b;
            ur = a % b;
            if (a == int_min && b == '1) begin
                sq = sa;
                sr = '0;
            end else begin
                sq = sa / sb;
                sr = sa % sb;
            end
        end

        result = product;
        wr_en  = 1'b1;
        case (op)
            4'(MDU_MADD), 4'(MDU_MADDU): result = acc + product;
            4'(MDU_MSUB), 4'(MDU_MSUBU): result = acc - product;
            4'(MDU_DIV): begin
                result = {sr, sq};
                wr_en  = (b != '0);
            end
            4'(MDU_DIVU): begin
                result = {ur, uq};
                wr_en  = (b != '0);
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mdu_unit.sv
// Multi-cycle multiply/divide unit owning HI/LO. The result is computed at
// acceptance, held pending for the op latency, then committed in one write.
module mdu_unit
    import mdu_unit_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int MULT_LAT = MDU_MULT_LAT,
    parameter int DIV_LAT  = MDU_DIV_LAT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             cancel,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CNT_W = mdu_cnt_width(MULT_LAT, DIV_LAT);

    typedef enum logic {IDLE, BUSY} state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2*WIDTH-1:0] pend_q, pend_d;
    logic               pend_wr_q, pend_wr_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;

    logic [2*WIDTH-1:0] calc_result;
    logic               calc_wr_en;
    logic               accept;

    mdu_calc #(
        .WIDTH (WIDTH)
    ) u_calc (
        .op     (op),
        .a      (A),
        .b      (B),
        .hi     (hi_q),
        .lo     (lo_q),
        .result (calc_result),
        .wr_en  (calc_wr_en)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pend_d    = pend_q;
        pend_wr_d = pend_wr_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        accept    = start && (state_q == IDLE) && !cancel && mdu_op_valid(op);

        case (state_q)
            IDLE: begin
                if (accept) begin
                    case (op)
                        4'(MDU_MTHI): hi_d = A;
                        4'(MDU_MTLO): lo_d = A;
                        4'(MDU_DIV), 4'(MDU_DIVU): begin
                            pend_d    = calc_result;
                            pend_wr_d = calc_wr_en;
                            cnt_d     = CNT_W'(DIV_LAT - 1);
                            state_d   = BUSY;
                        end
                        default: begin
                            pend_d    = calc_result;
                            pend_wr_d = calc_wr_en;
                            cnt_d     = CNT_W'(MULT_LAT - 1);
                            state_d   = BUSY;
                        end
                    endcase
                end
            end
            BUSY: begin
                if (cnt_q == '0) begin
                    if (pend_wr_q) begin
                        {hi_d, lo_d} = pend_q;
                    end
                    pend_wr_d = 1'b0;
                    state_d   = IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            pend_q    <= '0;
            pend_wr_q <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pend_q    <= pend_d;
            pend_wr_q <= pend_wr_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    assign busy = (state_q == BUSY);
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mdu_unit.sv
// Directed bench for mdu_unit with hand-computed HI/LO results and busy lengths.
module tb_mdu_unit;

    logic        clk;
    logic        reset;
    logic        start;
    logic [3:0]  op;
    logic [31:0] A;
    logic [31:0] B;
    logic        cancel;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    int vectors = 0;
    int errs    = 0;

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
    localparam logic [3:0] OP_MADD  = 4'd7;
    localparam logic [3:0] OP_MADDU = 4'd8;
    localparam logic [3:0] OP_MSUB  = 4'd9;
    localparam logic [3:0] OP_MSUBU = 4'd10;

    mdu_unit #(
        .WIDTH    (32),
        .MULT_LAT (5),
        .DIV_LAT  (10)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .op     (op),
        .A      (A),
        .B      (B),
        .cancel (cancel),
        .busy   (busy),
        .hi     (hi),
        .lo     (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "bench timed out");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic run_op(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                          input int lat, input string tag);
        int n;
        @(negedge clk);
        start = 1'b1; op = o; A = a; B = b;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (busy && n < 100) begin
            n++;
            @(negedge clk);
        end
        check({tag, " busy cycles"}, 64'(n), 64'(lat));
    endtask

    task automatic try_ignored(input logic [3:0] o, input logic [31:0] a, input logic c,
                               input logic [63:0] exp, input string tag);
        @(negedge clk);
        start = 1'b1; op = o; A = a; B = 32'd1; cancel = c;
        @(negedge clk);
        start = 1'b0; cancel = 1'b0;
        check({tag, " busy"}, 64'(busy), 64'd0);
        check({tag, " hilo"}, {hi, lo}, exp);
    endtask

    initial begin
        int n;
        reset = 1'b1; start = 1'b0; op = '0; A = '0; B = '0; cancel = 1'b0;
        #3;
        check("reset hilo", {hi, lo}, 64'h0);
        check("reset busy", 64'(busy), 64'd0);
        @(negedge clk);
        reset = 1'b0;

        run_op(OP_MULT, 32'hFFFFFFFE, 32'd3, 5, "mult");
        check("mult hilo", {hi, lo}, 64'hFFFFFFFF_FFFFFFFA);
        run_op(OP_MULTU, 32'hFFFFFFFE, 32'd3, 5, "multu");
        check("multu hilo", {hi, lo}, 64'h00000002_FFFFFFFA);
        run_op(OP_MULT, 32'h80000000, 32'h80000000, 5, "mult min");
        check("mult min hilo", {hi, lo}, 64'h40000000_00000000);

        run_op(OP_DIV, 32'hFFFFFFF9, 32'd2, 10, "div");
        check("div hilo", {hi, lo}, 64'hFFFFFFFF_FFFFFFFD);
        run_op(OP_DIV, 32'h80000000, 32'hFFFFFFFF, 10, "div ovf");
        check("div ovf hilo", {hi, lo}, 64'h00000000_80000000);
        run_op(OP_DIVU, 32'd100, 32'd7, 10, "divu");
        check("divu hilo", {hi, lo}, 64'h00000002_0000000E);

        run_op(OP_MTHI, 32'd5, 32'd0, 0, "mthi");
        check("mthi hi", 64'(hi), 64'd5);
        run_op(OP_MTLO, 32'd7, 32'd0, 0, "mtlo");
        run_op(OP_DIVU, 32'd9, 32'd0, 10, "divu0");
        check("divu0 hilo", {hi, lo}, 64'h00000005_00000007);

        run_op(OP_MTHI, 32'd0, 32'd0, 0, "mthi0");
        run_op(OP_MTLO, 32'd10, 32'd0, 0, "mtlo10");
        run_op(OP_MSUB, 32'd3, 32'd4, 5, "msub");
        check("msub hilo", {hi, lo}, 64'hFFFFFFFF_FFFFFFFE);
        run_op(OP_MADD, 32'hFFFFFFFF, 32'd1, 5, "madd");
        check("madd hilo", {hi, lo}, 64'hFFFFFFFF_FFFFFFFD);

        run_op(OP_MTHI, 32'd0, 32'd0, 0, "mthi0b");
        run_op(OP_MTLO, 32'd1, 32'd0, 0, "mtlo1");
        run_op(OP_MADDU, 32'hFFFFFFFF, 32'd2, 5, "maddu");
        check("maddu hilo", {hi, lo}, 64'h00000001_FFFFFFFF);
        run_op(OP_MSUBU, 32'd1, 32'hFFFFFFFF, 5, "msubu");
        check("msubu hilo", {hi, lo}, 64'h00000001_00000000);

        // Start while busy and cancel while busy must not disturb the MULT.
        run_op(OP_MTHI, 32'hA, 32'd0, 0, "mthi a");
        run_op(OP_MTLO, 32'hB, 32'd0, 0, "mtlo b");
        @(negedge clk);
        start = 1'b1; op = OP_MULT; A = 32'd6; B = 32'd7;
        @(negedge clk);
        start = 1'b0;
        n = int'(busy);
        @(negedge clk);
        n += int'(busy);
        start = 1'b1; op = OP_MTHI; A = 32'hDEAD;
        @(negedge clk);
        n += int'(busy);
        start = 1'b0; cancel = 1'b1;
        check("busy hold hilo", {hi, lo}, 64'h0000000A_0000000B);
        @(negedge clk);
        cancel = 1'b0;
        n += int'(busy);
        while (busy && n < 100) begin
            @(negedge clk);
            n += int'(busy);
        end
        check("interfere busy cycles", 64'(n), 64'd5);
        check("interfere hilo", {hi, lo}, 64'h00000000_0000002A);

        try_ignored(OP_MTLO, 32'h55, 1'b1, 64'h00000000_0000002A, "cancel mtlo");
        try_ignored(OP_MULT, 32'h3, 1'b1, 64'h00000000_0000002A, "cancel mult");
        try_ignored(4'd0, 32'h77, 1'b0, 64'h00000000_0000002A, "op0");
        try_ignored(4'd11, 32'h77, 1'b0, 64'h00000000_0000002A, "op11");

        // Reset in the fourth busy cycle abandons the DIV.
        @(negedge clk);
        start = 1'b1; op = OP_DIV; A = 32'd100; B = 32'd3;
        @(negedge clk);
        start = 1'b0;
        check("rst div busy", 64'(busy), 64'd1);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        #1;
        check("mid reset hilo", {hi, lo}, 64'h0);
        check("mid reset busy", 64'(busy), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (12) @(negedge clk);
        check("post reset hilo", {hi, lo}, 64'h0);
        check("post reset busy", 64'(busy), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
